// File: rtl/axil_xbar_pkg.sv
// axil_xbar_pkg: response codes and FSM state encoding shared by the crossbar response paths
package axil_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD    = 2'd1,
        ST_DECERR = 2'd2,
        ST_FLUSH  = 2'd3
    } xbar_state_e;

endpackage

// File: rtl/axil_crossbar_rd_resp.sv
// axil_crossbar_rd_resp: per-slave R return path; forwards one beat from the selected master or synthesizes DECERR (optional watchdog: AXIL_RESP_TIMEOUT_EN)
module axil_crossbar_rd_resp
    import axil_xbar_pkg::*;
#(
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024,
    localparam int CL_M      = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CL_M-1:0]               s_rc_select,
    input  logic                          s_rc_decerr,
    input  logic                          s_rc_valid,
    output logic                          s_rc_ready,
    input  logic [M_COUNT*DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [M_COUNT*2-1:0]          m_axil_rresp,
    input  logic [M_COUNT-1:0]            m_axil_rvalid,
    output logic [M_COUNT-1:0]            m_axil_rready,
    output logic [DATA_WIDTH-1:0]         s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic                          timeout_flag
);

    if (M_COUNT < 1) begin : g_bad_m_count
        $error("M_COUNT must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    xbar_state_e             r_state, w_next;
    logic [CL_M-1:0]         r_sel;
    logic [DATA_WIDTH-1:0]   r_rdata, w_data, w_ld_data;
    logic [1:0]              r_rresp, w_resp, w_ld_resp;
    logic                    r_rvalid, w_load, w_free, w_beat;
    logic [M_COUNT-1:0]      w_hit, w_rready;

    assign w_free        = !r_rvalid || s_axil_rready;
    assign w_beat        = |(m_axil_rvalid & w_hit);
    assign s_rc_ready    = r_state == ST_IDLE;
    assign m_axil_rready = w_rready;
    assign s_axil_rdata  = r_rdata;
    assign s_axil_rresp  = r_rresp;
    assign s_axil_rvalid = r_rvalid;

    // one-hot decode of the latched select and mux of that master's R payload
    always_comb begin
        w_hit  = '0;
        w_data = '0;
        w_resp = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            w_hit[i] = r_sel == CL_M'(i);
            w_data   = w_hit[i] ? m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] : w_data;
            w_resp   = w_hit[i] ? m_axil_rresp[i*2 +: 2] : w_resp;
        end
    end

`ifdef AXIL_RESP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
    logic [CW-1:0] r_cnt;
    logic          r_flag, w_to, w_expired;

    assign w_expired    = r_cnt == LIM;
    assign timeout_flag = r_flag;

    // watchdog: counts FWD cycles without a beat, saturating at the limit; sticky flag on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else begin
            r_cnt  <= (r_state != ST_FWD) ? '0 : w_expired ? r_cnt : r_cnt + 1'b1;
            r_flag <= r_flag | w_to;
        end
    end
`else
    assign timeout_flag = 1'b0;
`endif

    // next-state, master ready and output-register load decisions
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_ld_data = '0;
        w_ld_resp = RESP_DECERR;
        w_rready  = '0;
`ifdef AXIL_RESP_TIMEOUT_EN
        w_to      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: w_next = s_rc_valid ? (s_rc_decerr ? ST_DECERR : ST_FWD) : ST_IDLE;
            ST_FWD: begin
                w_rready = w_hit & {M_COUNT{w_free}};
                if (w_beat && w_free) begin
                    w_load    = 1'b1;
                    w_ld_data = w_data;
                    w_ld_resp = w_resp;
                    w_next    = ST_IDLE;
                end
`ifdef AXIL_RESP_TIMEOUT_EN
                else if (w_expired && w_free) begin
                    w_load    = 1'b1;
                    w_ld_resp = RESP_SLVERR;
                    w_to      = 1'b1;
                    w_next    = ST_FLUSH;
                end
`endif
            end
            ST_DECERR: begin
                w_load = w_free;
                w_next = w_free ? ST_IDLE : ST_DECERR;
            end
`ifdef AXIL_RESP_TIMEOUT_EN
            ST_FLUSH: begin
                w_rready = w_hit;
                w_next   = w_beat ? ST_IDLE : ST_FLUSH;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // state, latched select and the slave-side output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_rresp  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sel    <= (r_state == ST_IDLE && s_rc_valid) ? s_rc_select : r_sel;
            r_rdata  <= w_load ? w_ld_data : r_rdata;
            r_rresp  <= w_load ? w_ld_resp : r_rresp;
            r_rvalid <= w_load || (r_rvalid && !s_axil_rready);
        end
    end

endmodule

// File: tb/tb_axil_crossbar_rd_resp.sv
// tb_axil_crossbar_rd_resp: directed vector table plus hand sequences for backpressure, reset and watchdog
module tb_axil_crossbar_rd_resp;

    localparam int M  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      s_rc_select = '0;
    logic            s_rc_decerr = 1'b0;
    logic            s_rc_valid = 1'b0;
    logic            s_rc_ready;
    logic [M*DW-1:0] m_axil_rdata = '0;
    logic [M*2-1:0]  m_axil_rresp = '0;
    logic [M-1:0]    m_axil_rvalid = '0;
    logic [M-1:0]    m_axil_rready;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            s_axil_rvalid;
    logic            s_axil_rready = 1'b1;
    logic            timeout_flag;
    int              total = 0;
    int              bad = 0;

    typedef struct {
        logic [1:0]  sel;
        logic        dec;
        logic [3:0]  mv;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  exp_rr;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    axil_crossbar_rd_resp #(.M_COUNT(M), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rc_select(s_rc_select), .s_rc_decerr(s_rc_decerr), .s_rc_valid(s_rc_valid), .s_rc_ready(s_rc_ready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp), .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .timeout_flag(timeout_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_masters(input logic [3:0] mv, input int sel, input logic [31:0] d, input logic [1:0] r);
        for (int i = 0; i < M; i++) begin
            m_axil_rdata[i*DW +: DW] = (i == sel) ? d : ~d ^ i;
            m_axil_rresp[i*2 +: 2]   = (i == sel) ? r : ~r;
        end
        m_axil_rvalid = mv;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        s_axil_rready = 1'b1;
        set_masters(v.mv, v.sel, v.data, v.resp);
        s_rc_select = v.sel;
        s_rc_decerr = v.dec;
        s_rc_valid  = 1'b1;
        #1 chk($sformatf("v%0d_cmd_ready", idx), s_rc_ready, 1);
        @(negedge clk);
        s_rc_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_mrready", idx), m_axil_rready, v.exp_rr);
        chk($sformatf("v%0d_early_valid", idx), s_axil_rvalid, 0);
        @(negedge clk);
        m_axil_rvalid = '0;
        #1;
        chk($sformatf("v%0d_valid", idx), s_axil_rvalid, 1);
        chk($sformatf("v%0d_data", idx), s_axil_rdata, v.exp_data);
        chk($sformatf("v%0d_resp", idx), s_axil_rresp, v.exp_resp);
        chk($sformatf("v%0d_mrready_idle", idx), m_axil_rready, 0);
    endtask

    initial begin
        vecs[0] = '{2'd2, 1'b0, 4'b0100, 32'hDEADBEEF, 2'b00, 4'b0100, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{2'd0, 1'b1, 4'b0000, 32'h11111111, 2'b00, 4'b0000, 32'h00000000, 2'b11};
        vecs[2] = '{2'd3, 1'b0, 4'b1001, 32'hCAFEF00D, 2'b10, 4'b1000, 32'hCAFEF00D, 2'b10};
        vecs[3] = '{2'd0, 1'b0, 4'b0001, 32'h12345678, 2'b01, 4'b0001, 32'h12345678, 2'b01};
        vecs[4] = '{2'd1, 1'b0, 4'b1111, 32'hA5A5A5A5, 2'b11, 4'b0010, 32'hA5A5A5A5, 2'b11};
        vecs[5] = '{2'd3, 1'b1, 4'b1000, 32'h55555555, 2'b00, 4'b0000, 32'h00000000, 2'b11};

        #2;
        chk("rst_valid", s_axil_rvalid, 0);
        chk("rst_data", s_axil_rdata, 0);
        chk("rst_resp", s_axil_rresp, 0);
        chk("rst_flag", timeout_flag, 0);
        chk("rst_cmd_ready", s_rc_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // backpressure: output held by a DECERR beat while a master 1 command waits
        @(negedge clk);
        s_axil_rready = 1'b0;
        set_masters(4'b0000, 1, 32'h0BADF00D, 2'b00);
        s_rc_decerr = 1'b1;
        s_rc_valid  = 1'b1;
        @(negedge clk);
        s_rc_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_first_valid", s_axil_rvalid, 1);
        chk("bp_cmd2_ready", s_rc_ready, 1);
        s_rc_select = 2'd1;
        s_rc_decerr = 1'b0;
        s_rc_valid  = 1'b1;
        m_axil_rvalid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_rc_valid = 1'b0;
            #1;
            chk($sformatf("bp_hold_rr%0d", c), m_axil_rready, 0);
            chk($sformatf("bp_hold_valid%0d", c), s_axil_rvalid, 1);
            chk($sformatf("bp_hold_data%0d", c), s_axil_rdata, 0);
            chk($sformatf("bp_hold_resp%0d", c), s_axil_rresp, 2'b11);
        end
        s_axil_rready = 1'b1;
        #1 chk("bp_release_rr", m_axil_rready, 4'b0010);
        @(negedge clk);
        m_axil_rvalid = '0;
        #1;
        chk("bp_reload_valid", s_axil_rvalid, 1);
        chk("bp_reload_data", s_axil_rdata, 32'h0BADF00D);
        chk("bp_reload_resp", s_axil_rresp, 2'b00);
        @(negedge clk);
        #1 chk("bp_drained", s_axil_rvalid, 0);

        // reset while waiting in FWD with a held beat in the output register
        @(negedge clk);
        s_axil_rready = 1'b0;
        set_masters(4'b0100, 2, 32'h77777777, 2'b00);
        s_rc_select = 2'd2;
        s_rc_valid  = 1'b1;
        @(negedge clk);
        s_rc_valid = 1'b0;
        @(negedge clk);
        m_axil_rvalid = '0;
        s_rc_select = 2'd0;
        s_rc_valid  = 1'b1;
        @(negedge clk);
        s_rc_valid = 1'b0;
        #1;
        chk("rs_in_fwd", s_rc_ready, 0);
        chk("rs_held_valid", s_axil_rvalid, 1);
        m_axil_rvalid = 4'b0001;
        s_axil_rready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", s_axil_rvalid, 0);
        chk("rs_data", s_axil_rdata, 0);
        chk("rs_resp", s_axil_rresp, 0);
        chk("rs_mrready", m_axil_rready, 0);
        chk("rs_cmd_ready", s_rc_ready, 1);
        m_axil_rvalid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec(vecs[0], 10);

`ifdef AXIL_RESP_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            s_axil_rready = 1'b1;
            set_masters(4'b0000, 1, 32'h99999999, 2'b00);
            s_rc_select = 2'd1;
            s_rc_decerr = 1'b0;
            s_rc_valid  = 1'b1;
            @(negedge clk);
            s_rc_valid = 1'b0;
            n = 0;
            while (!s_axil_rvalid && n < 20) begin
                @(negedge clk);
                n++;
            end
            #1;
            chk("to_latency", n, 8);
            chk("to_resp", s_axil_rresp, 2'b10);
            chk("to_data", s_axil_rdata, 0);
            chk("to_flag", timeout_flag, 1);
            chk("to_flush_no_cmd", s_rc_ready, 0);
            m_axil_rvalid = 4'b0010;
            #1 chk("to_flush_rr", m_axil_rready, 4'b0010);
            @(negedge clk);
            m_axil_rvalid = '0;
            #1;
            chk("to_back_idle", s_rc_ready, 1);
            chk("to_late_dropped", s_axil_rvalid, 0);
            chk("to_flag_sticky", timeout_flag, 1);
        end
`else
        chk("flag_tied_low", timeout_flag, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
